// File: rtl/temporizador_multicanal.sv
// Multi-channel sequential dose timer: channels run from NUM_CH-1 down to 0, each on for its snapshotted count.
// Optional auto-restart (loop) mode is enabled by defining TMR_LOOP_EN.
module temporizador_multicanal #(
    parameter int unsigned NUM_CH = 3,
    parameter int unsigned CNT_W  = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      abort,
    input  logic                      loop,
    input  logic [NUM_CH*CNT_W-1:0]   ciclos,
    output logic [NUM_CH-1:0]         on,
    output logic [NUM_CH-1:0]         flags,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] ch_idx,
    output logic                      busy,
    output logic                      done
);

    localparam int unsigned IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned SNAP_W = NUM_CH * CNT_W;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [SNAP_W-1:0]  snap_q, snap_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   ch_d;
    logic               done_d;

    // Count programmed for channel idx within a packed snapshot.
    function automatic logic [CNT_W-1:0] cnt_of(input logic [SNAP_W-1:0] s,
                                                input logic [IDX_W-1:0]  idx);
        cnt_of = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (idx == IDX_W'(i)) cnt_of = s[i*CNT_W +: CNT_W];
        end
    endfunction

    // Highest-index nonzero channel strictly below lim; returns 1 if one exists.
    function automatic logic find_nz(input  logic [SNAP_W-1:0] s,
                                     input  int unsigned       lim,
                                     output logic [IDX_W-1:0]  idx);
        find_nz = 1'b0;
        idx     = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (i < lim && s[i*CNT_W +: CNT_W] != '0) begin
                find_nz = 1'b1;
                idx     = IDX_W'(i);
            end
        end
    endfunction

`ifndef TMR_LOOP_EN
    logic unused_loop;
    assign unused_loop = loop;
`endif

    // Next-state, next-counter and channel selection.
    always_comb begin
        logic             found;
        logic [IDX_W-1:0] nidx;
        state_d = state_q;
        snap_d  = snap_q;
        cnt_d   = cnt_q;
        ch_d    = ch_idx;
        done_d  = 1'b0;
        found   = 1'b0;
        nidx    = '0;
        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    snap_d = ciclos;
                    found  = find_nz(ciclos, NUM_CH, nidx);
                    if (found) begin
                        state_d = RUN;
                        ch_d    = nidx;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        done_d  = 1'b1;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    ch_d    = '0;
                end else if (cnt_q == cnt_of(snap_q, ch_idx)) begin
                    found = find_nz(snap_q, 32'(ch_idx), nidx);
                    if (found) begin
                        ch_d  = nidx;
                        cnt_d = CNT_W'(1);
                    end else begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                        cnt_d   = '0;
                        ch_d    = '0;
`ifdef TMR_LOOP_EN
                        if (loop) begin
                            snap_d = ciclos;
                            if (find_nz(ciclos, NUM_CH, nidx)) begin
                                state_d = RUN;
                                ch_d    = nidx;
                                cnt_d   = CNT_W'(1);
                            end
                        end
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs, derived from next-cycle values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            snap_q  <= '0;
            cnt_q   <= '0;
            ch_idx  <= '0;
            on      <= '0;
            flags   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            cnt_q   <= cnt_d;
            ch_idx  <= ch_d;
            busy    <= (state_d == RUN);
            done    <= done_d;
            if (state_d == RUN) begin
                on    <= NUM_CH'(1) << ch_d;
                flags <= (cnt_d == cnt_of(snap_d, ch_d)) ? (NUM_CH'(1) << ch_d) : '0;
            end else begin
                on    <= '0;
                flags <= '0;
            end
        end
    end

endmodule
